// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard control slice.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents: divide FSM state encoding, the per-stage stall/flush control
// bundle, the x0 register index and the load-use comparator.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // One bit per pipeline register: hold (stall*) or clear to bubble (flush*).
    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic stallM;
        logic flushD;
        logic flushE;
        logic flushM;
        logic flushW;
    } pipe_ctrl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A load in Execute whose destination feeds either Decode source cannot be
    // forwarded in time. x0 is hardwired to zero, so it never creates a hazard.
    function automatic logic load_use_hit(
        input logic       is_load,
        input logic [4:0] rd_e,
        input logic [4:0] rs1_d,
        input logic [4:0] rs2_d
    );
        return is_load && (rd_e != REG_X0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

endpackage

// File: rtl/div_stall_fsm.sv
// Divide-latency tracker: holds Execute for DIV_LAT cycles, then flags the result valid for one cycle.
// Latency: div_stall is combinational (asserted in the same cycle as div_start); div_busy/div_done are registered.
// Backpressure: freeze (memory wait) holds state and counter and blocks acceptance of a new divide.
//
// Ports:
//   clk, rst         core clock, asynchronous active-low reset
//   freeze           memory stall in progress; no state change this cycle
//   div_start        divide instruction present in Execute
//   div_stall        divide needs Execute held this cycle
//   div_busy         state != IDLE (registered)
//   div_done         state == DIV_DONE, result valid in Execute (registered)
module div_stall_fsm
    import hazard_pkg::*;
#(
    parameter int DIV_LAT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    input  logic div_start,
    output logic div_stall,
    output logic div_busy,
    output logic div_done
);

    // The IDLE cycle that accepts the divide is itself a stall cycle, so the
    // busy phase only has to cover DIV_LAT-1 more cycles: DIV_LAT-2 .. 0.
    localparam logic [7:0] CNT_INIT = (DIV_LAT > 1) ? 8'(DIV_LAT - 2) : 8'd0;

    div_state_t state;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
        end else if (!freeze) begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        div_busy <= 1'b1;
                        if (DIV_LAT == 1) begin
                            state    <= DIV_DONE;
                            div_done <= 1'b1;
                        end else begin
                            state    <= DIV_BUSY;
                            cnt      <= CNT_INIT;
                            div_done <= 1'b0;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (cnt == 8'd0) begin
                        state    <= DIV_DONE;
                        div_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DIV_DONE: begin
                    // div_start is still high from the same instruction; ignore it.
                    state    <= IDLE;
                    div_busy <= 1'b0;
                    div_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= 8'd0;
                    div_busy <= 1'b0;
                    div_done <= 1'b0;
                end
            endcase
        end
    end

    // Stall starts in the accepting IDLE cycle so the divide never slips past Execute.
    assign div_stall = ((state == IDLE) && div_start) || (state == DIV_BUSY);

endmodule

// File: rtl/stall_flush_unit.sv
// Pipeline stall/flush generator for hazards forwarding cannot cover (load-use, branch, divide, memory wait).
// Latency: all stall/flush outputs are combinational (zero cycles); StallCount updates at the following edge.
// Backpressure: memory wait dominates and freezes everything; divide dominates load-use and branch.
//
// Ports:
//   clk, rst                      core clock, asynchronous active-low reset
//   Rs1_D, Rs2_D, RD_E            Decode sources, Execute destination
//   ResultSrcE0                   Execute holds a load
//   PCSrcE                        taken branch/jump resolved in Execute
//   DivStartE                     divide in Execute
//   MemReqM, DMemReady            Memory-stage access and its completion
//   StallF/D/E/M, FlushD/E/M/W    per-stage hold / bubble controls
//   DivBusy, DivDoneE             divide FSM status
//   StallCount                    saturating count of cycles with StallF
module stall_flush_unit
    import hazard_pkg::*;
#(
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       RD_E,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             DivStartE,
    input  logic             MemReqM,
    input  logic             DMemReady,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             DivBusy,
    output logic             DivDoneE,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       mem_stall;
    logic       lw_stall;
    logic       div_stall;
    pipe_ctrl_t ctrl;

    assign mem_stall = MemReqM && !DMemReady;
    assign lw_stall  = load_use_hit(ResultSrcE0, RD_E, Rs1_D, Rs2_D);

    div_stall_fsm #(
        .DIV_LAT (DIV_LAT)
    ) u_div_fsm (
        .clk       (clk),
        .rst       (rst),
        .freeze    (mem_stall),
        .div_start (DivStartE),
        .div_stall (div_stall),
        .div_busy  (DivBusy),
        .div_done  (DivDoneE)
    );

    // Priority: memory wait > divide > branch > load-use.
    // Memory wait holds F..M and bubbles W, since the M instruction cannot retire.
    // Divide holds F..E and bubbles M; a branch or load-use flush of E would kill it.
    // A taken branch squashes Decode, so a load-use stall on it would be pointless.
    // Outputs are forced low while reset is asserted so an abort is seen immediately.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            ctrl = '0;
        end else if (mem_stall) begin
            ctrl.stallF = 1'b1;
            ctrl.stallD = 1'b1;
            ctrl.stallE = 1'b1;
            ctrl.stallM = 1'b1;
            ctrl.flushW = 1'b1;
        end else if (div_stall) begin
            ctrl.stallF = 1'b1;
            ctrl.stallD = 1'b1;
            ctrl.stallE = 1'b1;
            ctrl.flushM = 1'b1;
        end else if (PCSrcE) begin
            ctrl.flushD = 1'b1;
            ctrl.flushE = 1'b1;
        end else if (lw_stall) begin
            ctrl.stallF = 1'b1;
            ctrl.stallD = 1'b1;
            ctrl.flushE = 1'b1;
        end
    end

    assign StallF = ctrl.stallF;
    assign StallD = ctrl.stallD;
    assign StallE = ctrl.stallE;
    assign StallM = ctrl.stallM;
    assign FlushD = ctrl.flushD;
    assign FlushE = ctrl.flushE;
    assign FlushM = ctrl.flushM;
    assign FlushW = ctrl.flushW;

    // Performance counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCount <= '0;
        end else if (ctrl.stallF && (StallCount != CNT_MAX)) begin
            StallCount <= StallCount + CNT_ONE;
        end
    end

endmodule
